coin_feeder: RTL and testbench
==============================

Name: coin_feeder

Overview:
- Upstream partner of the newspaper vending FSM, on the coin side of its interface.
- Filters raw nickel and dime sensor levels, queues accepted coins, and presents them as one-cycle coin codes on the FSM's 2-bit coin input.
- Withholds codes while the vend FSM is dispensing, so no coin is lost in the dispense cycle.
- Rejects invalid or overflow coins through a return pulse.

Parameters:
- DEBOUNCE, 3: consecutive cycles a sensor must be stable to qualify or re-arm (min 1)
- DEPTH, 4: coin queue entries (power of two, min 2)
- GAP, 1: idle coin=00 cycles forced after each emitted code (min 0)
- JAM_CYCLES, 64: cycles a sensor may stay high after qualifying before jam is flagged

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- nickel_in  input  1  raw 5c sensor level, synchronous to clock
- dime_in  input  1  raw 10c sensor level, synchronous to clock
- newspaper  input  1  dispense indicator from vend FSM; 1 = coin input ignored this cycle
- coin  output  2  01 = 5c, 10 = 10c, 00 = none; never 11
- coin_return  output  1  one-cycle pulse, coin rejected
- queue_full  output  1  queue holds DEPTH entries
- jam  output  1  sticky sensor-jam flag, cleared only by reset

Behaviour:
- Reset, applied at any time, takes effect on the next clock edge:
  - coin=00, coin_return=0, queue_full=0, jam=0
  - queue emptied, both filters to IDLE, emitter to IDLE, all counters 0
  - An in-flight emitted code is abandoned and is not re-sent.
- Per-sensor filter FSM:
  - IDLE: sensor=1 -> COUNT_HI with count=1.
  - COUNT_HI: sensor=1 increments count; count reaching DEBOUNCE -> qualify event this cycle, go to HELD. sensor=0 -> IDLE, no event.
  - HELD: sensor=0 -> COUNT_LO with count=1. Otherwise the held counter increments; reaching JAM_CYCLES sets jam. The filter stays in HELD, so no further events occur.
  - COUNT_LO: sensor=0 increments count; count reaching DEBOUNCE -> IDLE. sensor=1 -> HELD (glitch; no new event).
- Qualify arbitration, same cycle:
  - Nickel only -> enqueue 01. Dime only -> enqueue 10.
  - Both -> no enqueue, coin_return=1 next cycle.
  - Qualify while queue full (after accounting for a same-cycle dequeue) -> no enqueue, coin_return=1 next cycle.
- Queue: FIFO, DEPTH entries × 2 bits, wrap-around pointers plus occupancy count. Simultaneous enqueue and dequeue when full is accepted. queue_full is registered and reflects post-edge occupancy.
- Emitter FSM:
  - IDLE: queue non-empty and newspaper=0 -> drive coin = head entry this cycle (combinational from head), pop at this edge, go to GAP (or stay in IDLE when GAP=0).
  - GAP: coin=00 for GAP cycles, then IDLE.
  - newspaper=1 -> coin=00; head is held and no pop occurs.
  - Latency: a single coin on an empty queue with newspaper=0 appears on coin on the cycle after its qualify edge. Filter-to-coin minimum latency is DEBOUNCE+1 cycles from the first sensor-high cycle.
- Coins are delivered in qualify order; none are duplicated or dropped except through coin_return.
- Width rules: counters sized ceil(log2(max+1)); saturate, never wrap.

Optional Feature:
- Macro: COIN_FEEDER_TALLY_EN
- Defined:
  - Adds output tally [7:0]: running count in 5c units of coins emitted (01 adds 1, 10 adds 2).
  - Wraps modulo 256; reset to 0.
  - Adds output reject_cnt [7:0], saturating at 255.
- Undefined: neither port exists; no tally logic.

Test Plan:
- Reset values: reset high 2 cycles with nickel_in=1 -> coin=00, coin_return=0, queue_full=0, jam=0; then reset low with nickel_in held -> exactly one coin=01 pulse, 4 cycles after reset deassertion.
- Glitch reject: nickel_in high 2 cycles then low -> no coin, no coin_return. Then high 3 cycles -> single coin=01 pulse.
- Dispense hold: queue 01 and 10 while newspaper=1 for 5 cycles -> coin=00 throughout; newspaper drops -> coin=01, GAP cycle of 00, then coin=10.
- Overflow: DEPTH=4, newspaper=1, qualify 5 dimes -> queue_full=1 after the 4th; 5th yields coin_return pulse. Release -> exactly four 10 codes.
- Simultaneous sensors: both rise same cycle, held 3 cycles -> coin_return=1 one cycle, no coin emitted, queue unchanged.
- Jam and mid-operation reset: dime_in held high 70 cycles -> one 10 emitted, jam=1 from cycle DEBOUNCE+64. Reset with 2 coins queued -> queue empty, jam=0, no further coin codes.

Source files
------------

// File: rtl/coin_feeder_if.sv
// coin_feeder_if: sensor, vend-FSM coin link and status signals of the coin feeder.
//   nickel_in, dime_in : raw coin sensor levels (environment -> feeder)
//   newspaper          : dispense indicator from vend FSM (vend FSM -> feeder)
//   coin[1:0]          : coin code to vend FSM, 01 = 5c, 10 = 10c, 00 = none
//   coin_return        : one-cycle reject pulse
//   queue_full         : coin queue holds DEPTH entries
//   jam                : sticky sensor-jam flag
//   tally, reject_cnt  : only when COIN_FEEDER_TALLY_EN is defined
// master = the feeder itself, slave = its environment (sensors + vend FSM).
interface coin_feeder_if;
    logic       nickel_in;
    logic       dime_in;
    logic       newspaper;
    logic [1:0] coin;
    logic       coin_return;
    logic       queue_full;
    logic       jam;
`ifdef COIN_FEEDER_TALLY_EN
    logic [7:0] tally;
    logic [7:0] reject_cnt;
    modport master (
        input  nickel_in, dime_in, newspaper,
        output coin, coin_return, queue_full, jam, tally, reject_cnt
    );
    modport slave (
        output nickel_in, dime_in, newspaper,
        input  coin, coin_return, queue_full, jam, tally, reject_cnt
    );
`else
    modport master (
        input  nickel_in, dime_in, newspaper,
        output coin, coin_return, queue_full, jam
    );
    modport slave (
        output nickel_in, dime_in, newspaper,
        input  coin, coin_return, queue_full, jam
    );
`endif
endinterface

// File: rtl/coin_feeder.sv
// coin_feeder: debounces nickel/dime sensors, queues accepted coins and feeds them to the vend FSM.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : coin_feeder_if.master (sensors, newspaper in; coin, coin_return, queue_full, jam out)
// Optional: define COIN_FEEDER_TALLY_EN to add bus.tally (5c units emitted, wraps)
// and bus.reject_cnt (saturating reject count).
module coin_feeder #(
    parameter int DEBOUNCE   = 3,
    parameter int DEPTH      = 4,
    parameter int GAP        = 1,
    parameter int JAM_CYCLES = 64
) (
    input  logic          clock,
    input  logic          reset,
    coin_feeder_if.master bus
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int JW = $clog2(JAM_CYCLES + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {F_IDLE, F_COUNT_HI, F_HELD, F_COUNT_LO} filt_t;
    typedef enum logic {E_IDLE, E_GAP} emit_t;

    logic [1:0] sensor;
    logic [1:0] qual;
    logic [1:0] jam_hit;
    assign sensor = {bus.dime_in, bus.nickel_in};

    // Bit 0 filters the nickel sensor, bit 1 the dime sensor.
    for (genvar f = 0; f < 2; f++) begin : g_filt
        filt_t         state;
        filt_t         state_nxt;
        logic [DW-1:0] cnt;
        logic [JW-1:0] held;
        logic          cnt_done;
        // The current cycle is the one that brings the count to DEBOUNCE.
        assign cnt_done = int'(cnt) >= DEBOUNCE - 1;
        always_ff @(posedge clock) begin
            if (reset) begin
                state <= F_IDLE;
                cnt   <= '0;
                held  <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= (state == F_IDLE || state == F_HELD) ? DW'(1)
                       : (cnt == DW'(DEBOUNCE)) ? cnt : cnt + DW'(1);
                held  <= qual[f] ? '0
                       : (state == F_HELD && sensor[f] && held != JW'(JAM_CYCLES)) ? held + JW'(1)
                       : held;
            end
        end
        always_comb begin
            state_nxt = (state == F_IDLE)     ? (sensor[f] ? ((DEBOUNCE == 1) ? F_HELD : F_COUNT_HI) : F_IDLE)
                      : (state == F_COUNT_HI) ? (!sensor[f] ? F_IDLE : (cnt_done ? F_HELD : F_COUNT_HI))
                      : (state == F_HELD)     ? (sensor[f] ? F_HELD : ((DEBOUNCE == 1) ? F_IDLE : F_COUNT_LO))
                      : (sensor[f] ? F_HELD : (cnt_done ? F_IDLE : F_COUNT_LO));
        end
        assign qual[f]    = sensor[f] && ((state == F_IDLE && DEBOUNCE == 1) || (state == F_COUNT_HI && cnt_done));
        assign jam_hit[f] = state == F_HELD && sensor[f] && held == JW'(JAM_CYCLES - 1);
    end

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] q_cnt;
    logic [CW-1:0] q_cnt_nxt;
    logic          enq;
    logic          deq;
    logic          reject;

    // A full queue still accepts a coin when the head leaves in the same cycle.
    assign enq       = ^qual && (q_cnt != CW'(DEPTH) || deq);
    assign reject    = &qual || (^qual && !enq);
    assign q_cnt_nxt = q_cnt + CW'(enq) - CW'(deq);

    always_ff @(posedge clock) begin
        if (enq)
            mem[wp] <= qual[1] ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp              <= '0;
            rp              <= '0;
            q_cnt           <= '0;
            bus.queue_full  <= 1'b0;
            bus.coin_return <= 1'b0;
            bus.jam         <= 1'b0;
        end else begin
            wp              <= wp + AW'(enq);
            rp              <= rp + AW'(deq);
            q_cnt           <= q_cnt_nxt;
            bus.queue_full  <= q_cnt_nxt == CW'(DEPTH);
            bus.coin_return <= reject;
            bus.jam         <= bus.jam | (|jam_hit);
        end
    end

    emit_t         e_state;
    emit_t         e_state_nxt;
    logic [GW-1:0] g_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            e_state <= E_IDLE;
            g_cnt   <= '0;
        end else begin
            e_state <= e_state_nxt;
            g_cnt   <= (e_state == E_IDLE) ? GW'(1) : (g_cnt == GW'(GAP)) ? g_cnt : g_cnt + GW'(1);
        end
    end

    always_comb begin
        e_state_nxt = (e_state == E_IDLE) ? ((deq && GAP > 0) ? E_GAP : E_IDLE)
                    : (int'(g_cnt) >= GAP) ? E_IDLE : E_GAP;
    end

    // The head is presented combinationally and popped at the same edge; newspaper holds it.
    assign deq      = e_state == E_IDLE && q_cnt != '0 && !bus.newspaper;
    assign bus.coin = deq ? mem[rp] : 2'b00;

`ifdef COIN_FEEDER_TALLY_EN
    // The coin code value equals its worth in 5c units.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.tally      <= '0;
            bus.reject_cnt <= '0;
        end else begin
            bus.tally      <= bus.tally + {6'd0, bus.coin};
            bus.reject_cnt <= bus.reject_cnt + 8'(reject && bus.reject_cnt != 8'hFF);
        end
    end
`endif
endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder: scoreboard bench for coin_feeder with directed sensor vectors.
module tb_coin_feeder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    coin_feeder_if bus();

    coin_feeder #(.DEBOUNCE(3), .DEPTH(4), .GAP(1), .JAM_CYCLES(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int n_coins = 0;
    int last_cyc = -1;
    int prev_cyc = -1;
    int exp_ret = 0;
    logic [1:0] exp_coin[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a coin or a return pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.newspaper)
                check("coin_during_dispense", {30'd0, bus.coin}, 32'd0);
            if (bus.coin != 2'b00) begin
                if (exp_coin.size() == 0) begin
                    check("unexpected_coin", {30'd0, bus.coin}, 32'd0);
                end else begin
                    check("coin_code", {30'd0, bus.coin}, {30'd0, exp_coin.pop_front()});
                end
                n_coins++;
                prev_cyc = last_cyc;
                last_cyc = cyc;
            end
            if (bus.coin_return) begin
                check("coin_return_expected", {31'd0, exp_ret > 0}, 32'd1);
                if (exp_ret > 0) exp_ret--;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_dime();
        bus.dime_in = 1'b1;
        step(3);
        bus.dime_in = 1'b0;
        step(3);
    endtask

    task automatic pulse_nickel();
        bus.nickel_in = 1'b1;
        step(3);
        bus.nickel_in = 1'b0;
        step(3);
    endtask

    int t0;
    int base;

    initial begin
        bus.nickel_in = 1'b1;
        bus.dime_in   = 1'b0;
        bus.newspaper = 1'b0;
        // Reset with a sensor already high.
        step(2);
        check("reset_coin", {30'd0, bus.coin}, 32'd0);
        check("reset_coin_return", {31'd0, bus.coin_return}, 32'd0);
        check("reset_queue_full", {31'd0, bus.queue_full}, 32'd0);
        check("reset_jam", {31'd0, bus.jam}, 32'd0);
        exp_coin.push_back(2'b01);
        reset = 1'b0;
        t0 = cyc;
        step(8);
        bus.nickel_in = 1'b0;
        step(5);
        check("first_coin_latency", last_cyc - t0, 32'd3);
        check("first_coin_count", n_coins, 32'd1);

        // Glitch shorter than DEBOUNCE, then a valid pulse.
        bus.nickel_in = 1'b1;
        step(2);
        bus.nickel_in = 1'b0;
        step(5);
        check("glitch_no_coin", n_coins, 32'd1);
        exp_coin.push_back(2'b01);
        pulse_nickel();
        step(4);
        check("after_glitch_coin", n_coins, 32'd2);

        // Dispense hold: both coins wait until newspaper drops, then 01, gap, 10.
        bus.newspaper = 1'b1;
        exp_coin.push_back(2'b01);
        exp_coin.push_back(2'b10);
        bus.nickel_in = 1'b1;
        step(3);
        bus.nickel_in = 1'b0;
        bus.dime_in   = 1'b1;
        step(3);
        bus.dime_in   = 1'b0;
        step(3);
        check("hold_no_coin", n_coins, 32'd2);
        bus.newspaper = 1'b0;
        t0 = cyc;
        step(5);
        check("release_first_cycle", prev_cyc - t0, 32'd0);
        check("release_gap", last_cyc - prev_cyc, 32'd2);
        check("release_count", n_coins, 32'd4);

        // Overflow: four dimes fill the queue, the fifth is returned.
        bus.newspaper = 1'b1;
        repeat (3) pulse_dime();
        check("queue_not_full_3", {31'd0, bus.queue_full}, 32'd0);
        pulse_dime();
        check("queue_full_4", {31'd0, bus.queue_full}, 32'd1);
        exp_ret++;
        pulse_dime();
        check("overflow_return_seen", exp_ret, 32'd0);
        check("queue_full_kept", {31'd0, bus.queue_full}, 32'd1);
        repeat (4) exp_coin.push_back(2'b10);
        base = n_coins;
        bus.newspaper = 1'b0;
        step(12);
        check("overflow_drain_count", n_coins - base, 32'd4);
        check("queue_empty_after_drain", {31'd0, bus.queue_full}, 32'd0);

        // Simultaneous sensors: rejected, nothing queued.
        base = n_coins;
        exp_ret++;
        bus.nickel_in = 1'b1;
        bus.dime_in   = 1'b1;
        step(3);
        bus.nickel_in = 1'b0;
        bus.dime_in   = 1'b0;
        step(6);
        check("both_return_seen", exp_ret, 32'd0);
        check("both_no_coin", n_coins - base, 32'd0);

        // Jam: dime held for 70 cycles.
        base = n_coins;
        exp_coin.push_back(2'b10);
        bus.dime_in = 1'b1;
        step(66);
        check("jam_before", {31'd0, bus.jam}, 32'd0);
        step(1);
        check("jam_set", {31'd0, bus.jam}, 32'd1);
        step(3);
        bus.dime_in = 1'b0;
        step(2);
        check("jam_sticky", {31'd0, bus.jam}, 32'd1);
        check("jam_single_coin", n_coins - base, 32'd1);

        // Two coins queued then abandoned by reset.
        bus.newspaper = 1'b1;
        pulse_nickel();
        pulse_nickel();
        check("two_queued_not_full", {31'd0, bus.queue_full}, 32'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus.newspaper = 1'b0;
        check("midreset_jam", {31'd0, bus.jam}, 32'd0);
        check("midreset_queue_full", {31'd0, bus.queue_full}, 32'd0);
        base = n_coins;
        step(10);
        check("midreset_no_coins", n_coins - base, 32'd0);
        check("scoreboard_empty", exp_coin.size(), 32'd0);
        check("returns_consumed", exp_ret, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
